// File: rtl/tag_lookup_ctrl.sv
// rtl/tag_lookup_ctrl.sv - tag RAM lookup/allocate/flush controller; TAG_LOOKUP_STATS_EN adds hit/miss counters
module tag_lookup_ctrl #(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 7
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [AWIDTH-1:0]   req_index,
    input  logic [DWIDTH-2:0]   req_tag,
    input  logic                req_alloc,
    input  logic                flush_req,
    output logic                flush_done,
    output logic                resp_valid,
    output logic                resp_hit,
    output logic [AWIDTH-1:0]   resp_index,
    output logic [AWIDTH-1:0]   ram_addr,
    output logic [DWIDTH-1:0]   ram_din,
    output logic                ram_we,
    input  logic [DWIDTH-1:0]   ram_dout
`ifdef TAG_LOOKUP_STATS_EN
    ,
    output logic [15:0]         hit_count,
    output logic [15:0]         miss_count
`endif
);
    localparam int TWIDTH = DWIDTH - 1;
    localparam int DEPTH  = 1 << AWIDTH;
    localparam logic [AWIDTH-1:0] LAST_IDX = AWIDTH'(DEPTH - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOOKUP = 2'd1;
    localparam logic [1:0] S_ALLOC  = 2'd2;
    localparam logic [1:0] S_FLUSH  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [AWIDTH-1:0] idx_q, idx_d;
    logic [TWIDTH-1:0] tag_q, tag_d;
    logic              alloc_q, alloc_d;
    logic [AWIDTH-1:0] cnt_q, cnt_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_hit_q, resp_hit_d;
    logic [AWIDTH-1:0] resp_index_q, resp_index_d;
    logic              flush_done_q, flush_done_d;
    logic              hit;

    // RAM output is valid in LOOKUP because the address was presented at the accepting edge
    assign hit = ram_dout[DWIDTH-1] & (ram_dout[TWIDTH-1:0] == tag_q);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        tag_d        = tag_q;
        alloc_d      = alloc_q;
        cnt_d        = cnt_q;
        resp_valid_d = 1'b0;
        resp_hit_d   = resp_hit_q;
        resp_index_d = resp_index_q;
        flush_done_d = 1'b0;
        req_ready    = 1'b0;
        ram_addr     = idx_q;
        ram_din      = '0;
        ram_we       = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                ram_addr  = req_index;
                if (flush_req) begin
                    state_d = S_FLUSH;
                    cnt_d   = '0;
                end else if (req_valid) begin
                    idx_d   = req_index;
                    tag_d   = req_tag;
                    alloc_d = req_alloc;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit || !alloc_q) begin
                    resp_valid_d = 1'b1;
                    resp_hit_d   = hit;
                    resp_index_d = idx_q;
                    state_d      = S_IDLE;
                end else begin
                    state_d = S_ALLOC;
                end
            end
            S_ALLOC: begin
                ram_din      = {1'b1, tag_q};
                ram_we       = 1'b1;
                resp_valid_d = 1'b1;
                resp_hit_d   = 1'b0;
                resp_index_d = idx_q;
                state_d      = S_IDLE;
            end
            S_FLUSH: begin
                ram_addr = cnt_q;
                ram_we   = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    flush_done_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            tag_q        <= '0;
            alloc_q      <= 1'b0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_index_q <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            tag_q        <= tag_d;
            alloc_q      <= alloc_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_hit_q   <= resp_hit_d;
            resp_index_q <= resp_index_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_hit   = resp_hit_q;
    assign resp_index = resp_index_q;
    assign flush_done = flush_done_q;

`ifdef TAG_LOOKUP_STATS_EN
    logic [15:0] hit_count_q, miss_count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else if (resp_valid_q) begin
            if (resp_hit_q && hit_count_q != 16'hFFFF) begin
                hit_count_q <= hit_count_q + 16'd1;
            end
            if (!resp_hit_q && miss_count_q != 16'hFFFF) begin
                miss_count_q <= miss_count_q + 16'd1;
            end
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// tb/tb_tag_lookup_ctrl.sv - scoreboard bench for tag_lookup_ctrl with a synchronous-read RAM model
module tb_tag_lookup_ctrl;
    localparam int AW    = 3;
    localparam int DW    = 7;
    localparam int TW    = 6;
    localparam int DEPTH = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_index = '0;
    logic [TW-1:0] req_tag = '0;
    logic          req_alloc = 1'b0;
    logic          flush_req = 1'b0;
    logic          flush_done;
    logic          resp_valid;
    logic          resp_hit;
    logic [AW-1:0] resp_index;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_we;
    logic [DW-1:0] ram_dout = '0;
`ifdef TAG_LOOKUP_STATS_EN
    logic [15:0]   hit_count;
    logic [15:0]   miss_count;
`endif

    tag_lookup_ctrl #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_index  (req_index),
        .req_tag    (req_tag),
        .req_alloc  (req_alloc),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .resp_valid (resp_valid),
        .resp_hit   (resp_hit),
        .resp_index (resp_index),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_we     (ram_we),
        .ram_dout   (ram_dout)
`ifdef TAG_LOOKUP_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    typedef struct {
        int            cyc;
        logic          hit;
        logic [AW-1:0] idx;
    } resp_t;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
    } wr_t;

    resp_t         rq[$];
    wr_t           wq[$];
    int            fq[$];
    logic [DW-1:0] mem[DEPTH];
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_bad = 0;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Synchronous-read RAM with no reset; starts with valid-looking junk
    always @(posedge clock) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        resp_t e;
        wr_t   w;
        int    fc;
        if (!reset) begin
            if (resp_valid) begin
                if (rq.size() == 0) begin
                    chk("unexpected_resp", 32'(resp_index), 32'hFFFF_FFFF);
                end else begin
                    e = rq.pop_front();
                    chk("resp_cycle", 32'(cyc), 32'(e.cyc));
                    chk("resp_hit", 32'(resp_hit), 32'(e.hit));
                    chk("resp_index", 32'(resp_index), 32'(e.idx));
                end
            end
            if (ram_we) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write", 32'(ram_addr), 32'hFFFF_FFFF);
                end else begin
                    w = wq.pop_front();
                    chk("write_cycle", 32'(cyc), 32'(w.cyc));
                    chk("write_addr", 32'(ram_addr), 32'(w.addr));
                    chk("write_din", 32'(ram_din), 32'(w.din));
                end
            end else begin
                chk("din_zero_without_we", 32'(ram_din), 0);
            end
            if (flush_done) begin
                if (fq.size() == 0) begin
                    chk("unexpected_flush_done", 32'(cyc), 32'hFFFF_FFFF);
                end else begin
                    fc = fq.pop_front();
                    chk("flush_done_cycle", 32'(cyc), 32'(fc));
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!req_ready && k < 40) begin
            step();
            k++;
        end
        if (!req_ready) chk("ready_timeout", 32'(req_ready), 1);
    endtask

    // Drives one request; returns #1 after the response edge so the next call is back-to-back
    task automatic lookup(input logic [AW-1:0] idx, input logic [TW-1:0] tag,
                          input logic alloc, input logic exp_hit);
        int n;
        wait_ready();
        req_valid = 1'b1;
        req_index = idx;
        req_tag   = tag;
        req_alloc = alloc;
        n = cyc + 1;
        if (alloc && !exp_hit) begin
            wq.push_back('{cyc: n + 1, addr: idx, din: {1'b1, tag}});
            rq.push_back('{cyc: n + 2, hit: 1'b0, idx: idx});
        end else begin
            rq.push_back('{cyc: n + 1, hit: exp_hit, idx: idx});
        end
        step();
        req_valid = 1'b0;
        step();
        if (alloc && !exp_hit) step();
    endtask

    task automatic push_flush(input int e0, input int nwr);
        for (int i = 0; i < nwr; i++) begin
            wq.push_back('{cyc: e0 + i, addr: AW'(i), din: '0});
        end
    endtask

    task automatic do_flush();
        int e0;
        wait_ready();
        flush_req = 1'b1;
        e0 = cyc + 1;
        push_flush(e0, DEPTH);
        fq.push_back(e0 + DEPTH);
        step();
        flush_req = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            chk("ready_low_in_flush", 32'(req_ready), 0);
            step();
        end
        chk("ready_after_flush", 32'(req_ready), 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ram_we"}, 32'(ram_we), 0);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 0);
        chk({tag, "_resp_hit"}, 32'(resp_hit), 0);
        chk({tag, "_resp_index"}, 32'(resp_index), 0);
        chk({tag, "_flush_done"}, 32'(flush_done), 0);
        chk({tag, "_ram_din"}, 32'(ram_din), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 7'h55;

        step();
        step();
        chk_reset_outputs("reset");
        chk("reset_req_ready", 32'(req_ready), 1);
        reset = 1'b0;
        step();

        do_flush();
        lookup(3'd3, 6'h15, 1'b0, 1'b0);
        lookup(3'd3, 6'h15, 1'b1, 1'b0);
        lookup(3'd3, 6'h15, 1'b0, 1'b1);
        lookup(3'd3, 6'h2A, 1'b0, 1'b0);
        lookup(3'd3, 6'h15, 1'b0, 1'b1);

        // flush and request together: flush wins, request waits for IDLE
        wait_ready();
        flush_req = 1'b1;
        req_valid = 1'b1;
        req_index = 3'd3;
        req_tag   = 6'h15;
        req_alloc = 1'b0;
        e0 = cyc + 1;
        push_flush(e0, DEPTH);
        fq.push_back(e0 + DEPTH);
        rq.push_back('{cyc: e0 + DEPTH + 2, hit: 1'b0, idx: 3'd3});
        step();
        flush_req = 1'b0;
        repeat (DEPTH + 1) step();
        req_valid = 1'b0;
        step();

        lookup(3'd5, 6'h0A, 1'b1, 1'b0);
        lookup(3'd5, 6'h0A, 1'b0, 1'b1);

        // reset while in ALLOC: no write, no response
        wait_ready();
        req_valid = 1'b1;
        req_index = 3'd2;
        req_tag   = 6'h11;
        req_alloc = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        reset = 1'b1;
        #1;
        chk_reset_outputs("alloc_reset");
        step();
        reset = 1'b0;
        step();
        lookup(3'd2, 6'h11, 1'b0, 1'b0);

        // reset mid-FLUSH after three writes
        wait_ready();
        flush_req = 1'b1;
        e0 = cyc + 1;
        push_flush(e0, 3);
        step();
        flush_req = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        #1;
        chk_reset_outputs("flush_reset");
        step();
        reset = 1'b0;
`ifdef TAG_LOOKUP_STATS_EN
        chk("hit_count_reset", 32'(hit_count), 0);
        chk("miss_count_reset", 32'(miss_count), 0);
`endif
        repeat (DEPTH + 2) step();

        lookup(3'd5, 6'h0A, 1'b0, 1'b1);
        lookup(3'd5, 6'h0A, 1'b0, 1'b1);
        lookup(3'd5, 6'h0A, 1'b0, 1'b1);
        lookup(3'd6, 6'h01, 1'b0, 1'b0);
        lookup(3'd6, 6'h01, 1'b0, 1'b0);
        repeat (3) step();
`ifdef TAG_LOOKUP_STATS_EN
        chk("hit_count", 32'(hit_count), 3);
        chk("miss_count", 32'(miss_count), 2);
`endif

        repeat (4) step();
        chk("resp_queue_drained", 32'(rq.size()), 0);
        chk("write_queue_drained", 32'(wq.size()), 0);
        chk("flush_queue_drained", 32'(fq.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/tag_lookup_ctrl.md
# tag_lookup_ctrl

Lookup/allocate controller that drives the synchronous-read tag RAM (address, data-in, write-enable; dout valid the cycle after the address edge). It accepts index/tag requests over a valid/ready handshake and reads the entry at that index. It compares the stored tag and valid bit against the request and reports hit/miss. On a miss with allocate it writes the new tag. It also supports a full-array invalidate sweep (flush), since the RAM itself has no reset.

## Interface

Parameters:
- AWIDTH, 3, index width; DEPTH = 1 << AWIDTH entries
- DWIDTH, 7, RAM entry width; entry bit DWIDTH-1 = valid, bits DWIDTH-2:0 = tag (TWIDTH = DWIDTH-1)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  lookup request present
- req_ready  out  1  controller can accept a request
- req_index  in  AWIDTH  set index
- req_tag  in  TWIDTH  tag to compare
- req_alloc  in  1  on miss, write {1, req_tag} at req_index
- flush_req  in  1  start invalidate sweep (sampled in IDLE only)
- flush_done  out  1  one-cycle pulse, sweep complete
- resp_valid  out  1  one-cycle pulse, result valid
- resp_hit  out  1  1 = hit, 0 = miss; meaningful with resp_valid
- resp_index  out  AWIDTH  index of the answered request
- ram_addr  out  AWIDTH  to RAM addr
- ram_din  out  DWIDTH  to RAM din
- ram_we  out  1  to RAM we
- ram_dout  in  DWIDTH  from RAM dout

## Operation

- States: IDLE, LOOKUP, ALLOC, FLUSH.
- IDLE:
  - req_ready = 1.
  - ram_addr = req_index (combinational), ram_we = 0.
  - flush_req has priority over req_valid. flush_req -> FLUSH with flush counter = 0; the request is not accepted that cycle.
  - Otherwise req_valid -> latch index/tag/alloc, go to LOOKUP.
- LOOKUP:
  - ram_addr = latched index, which holds the RAM read address stable.
  - hit = ram_dout[DWIDTH-1] & (ram_dout[DWIDTH-2:0] == latched tag).
  - If hit, or if !alloc: register resp_valid=1, resp_hit=hit, resp_index, then go to IDLE.
  - If miss and alloc: go to ALLOC.
- ALLOC:
  - ram_addr = latched index, ram_din = {1'b1, tag}, ram_we = 1.
  - Register resp_valid=1, resp_hit=0, then go to IDLE.
- FLUSH:
  - ram_addr = counter, ram_din = 0, ram_we = 1.
  - Counter increments each cycle.
  - At counter == DEPTH-1: register flush_done=1, go to IDLE.
- No response backpressure: the consumer must take resp_* in the pulse cycle.
- ram_we is 0 in IDLE and LOOKUP. ram_din = 0 whenever ram_we = 0.

## Timing

- Request accepted at edge N: LOOKUP during cycle N..N+1, compare on ram_dout.
- Hit or no-alloc: resp_valid high in cycle following edge N+1 (latency 2). req_ready is high in that same cycle, so back-to-back requests run at 1 per 2 cycles.
- Miss with alloc: RAM write at edge N+2, resp_valid after edge N+2 (latency 3).
- A lookup accepted immediately after an allocate to the same index sees the new tag (hit).
- Flush occupies exactly DEPTH cycles. flush_done pulses in the cycle after the last write. req_ready = 0 throughout.
- Counter width is AWIDTH; DEPTH-1 is the final value, so there is no wrap.
- Reset (any time, including mid-LOOKUP/ALLOC/FLUSH):
  - State -> IDLE; resp_valid, resp_hit, resp_index, flush_done, and counter -> 0.
  - ram_we drops immediately.
  - The in-flight request or flush is abandoned with no response.
  - RAM contents are not touched.

## Configuration

- TAG_LOOKUP_STATS_EN defined:
  - Adds outputs hit_count[15:0] and miss_count[15:0].
  - Each increments on resp_valid according to resp_hit and saturates at 16'hFFFF.
  - Both clear on reset; flush does not clear them.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan

- Reset, then flush_req=1 for one cycle:
  - ram_we=1 for 8 consecutive cycles with ram_addr 0..7 and ram_din=0.
  - flush_done pulses once, then req_ready=1.
- After flush, request index=3 tag=6'h15 alloc=0:
  - resp_valid at latency 2, resp_hit=0, no RAM write.
- Request index=3 tag=6'h15 alloc=1:
  - ram_we at edge N+2 with ram_din=7'h55.
  - resp_hit=0 at latency 3.
  - An immediate re-request of the same index and tag gives resp_hit=1 at latency 2.
- Request index=3 tag=6'h2A alloc=0 after the allocate above: resp_hit=0 (tag mismatch), entry unchanged.
- flush_req and req_valid asserted together in IDLE: flush runs first; the request is accepted only after flush_done.
- Reset asserted during ALLOC and during FLUSH:
  - Outputs go to 0 immediately, with no resp_valid/flush_done.
  - With TAG_LOOKUP_STATS_EN, counters read 0. After 3 hits and 2 misses they read hit_count=3, miss_count=2.
